// File: rtl/ex_alu_muldiv.sv
// Execute-stage ALU: single-cycle integer ops plus an iterative shift-add
// multiplier and restoring divider that share one set of working registers.
module ex_alu_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] bus_a,
    input  logic [XLEN-1:0] bus_b,
    input  logic [XLEN-1:0] imm,
    input  logic [3:0]      alu_ctr,
    input  logic            a_src,
    input  logic [1:0]      b_src,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_out,
    output logic [XLEN-1:0] target,
    output logic            zero,
    output logic            busy
);
    localparam int CW = $clog2(XLEN + 1);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_PASS = 4'b1111;
    localparam logic [3:0] OP_MUL  = 4'b1001;
    localparam logic [3:0] OP_DIV  = 4'b1100;
    localparam logic [3:0] OP_DIVU = 4'b1101;
    localparam logic [3:0] OP_REM  = 4'b1110;
    localparam logic [3:0] OP_REMU = 4'b1011;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
    state_t state, state_nxt;

    logic [XLEN-1:0] op_a, op_b, result, mag_a, mag_b;
    logic [XLEN-1:0] acc, shreg, opnd, dividend;
    logic [XLEN-1:0] acc_step, shreg_step, quot, rem, mc_result;
    logic [XLEN:0]   trial;
    logic [CW-1:0]   count;
    logic is_mul, is_div, div_signed, div_rem, a_neg, b_neg;
    logic accept, last, finish;
    logic want_rem, neg_q, neg_r, div_zero;

    assign is_mul     = (alu_ctr == OP_MUL);
    assign is_div     = (alu_ctr == OP_DIV) || (alu_ctr == OP_DIVU) ||
                        (alu_ctr == OP_REM) || (alu_ctr == OP_REMU);
    assign div_signed = (alu_ctr == OP_DIV) || (alu_ctr == OP_REM);
    assign div_rem    = (alu_ctr == OP_REM) || (alu_ctr == OP_REMU);
    assign accept     = in_valid && in_ready;
    assign last       = (count == CW'(XLEN - 1));
    assign finish     = busy && last && !flush;

    assign op_a  = a_src ? pc : bus_a;
    assign a_neg = div_signed && op_a[XLEN-1];
    assign b_neg = div_signed && op_b[XLEN-1];
    assign mag_a = a_neg ? -op_a : op_a;
    assign mag_b = b_neg ? -op_b : op_b;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        op_b = '0;
        case (b_src)
            2'b00:   op_b = bus_b;
            2'b01:   op_b = XLEN'(4);
            2'b10:   op_b = imm;
            default: op_b = '0;
        endcase
    end

    always_comb begin
        result = '0;
        case (alu_ctr)
            OP_ADD:  result = op_a + op_b;
            OP_SUB:  result = op_a - op_b;
            OP_SLT:  result = XLEN'($signed(op_a) < $signed(op_b));
            OP_SLTU: result = XLEN'(op_a < op_b);
            OP_OR:   result = op_a | op_b;
            OP_AND:  result = op_a & op_b;
            OP_XOR:  result = op_a ^ op_b;
            OP_PASS: result = op_b;
            default: result = '0;
        endcase
    end

    // One iteration step; the final step's value is written straight to alu_out.
    always_comb begin
        trial = {acc, shreg[XLEN-1]} - {1'b0, opnd};
        if (state == MUL) begin
            acc_step   = acc + (shreg[0] ? opnd : '0);
            shreg_step = shreg >> 1;
        end else begin
            acc_step   = trial[XLEN] ? {acc[XLEN-2:0], shreg[XLEN-1]} : trial[XLEN-1:0];
            shreg_step = {shreg[XLEN-2:0], ~trial[XLEN]};
        end
        quot = neg_q ? -shreg_step : shreg_step;
        rem  = neg_r ? -acc_step : acc_step;
        if (div_zero) begin
            quot = '1;
            rem  = dividend;
        end
        if (state == MUL) mc_result = acc_step;
        else              mc_result = want_rem ? rem : quot;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && is_mul)      state_nxt = MUL;
                    else if (accept && is_div) state_nxt = DIV;
                end
                MUL, DIV: if (last) state_nxt = IDLE;
                default:  state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy     = (state != IDLE);
        in_ready = (state == IDLE) && (!out_valid || out_ready) && !flush;
    end

    // NOTE: the working registers are reset too, so nothing X can leak into a result after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            alu_out   <= '0;
            target    <= '0;
            zero      <= 1'b1;
            count     <= '0;
            acc       <= '0;
            shreg     <= '0;
            opnd      <= '0;
            dividend  <= '0;
            div_zero  <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            want_rem  <= 1'b0;
        end else begin
            if (accept) begin
                target   <= pc + imm;
                count    <= '0;
                acc      <= '0;
                shreg    <= is_mul ? op_b : mag_a;
                opnd     <= is_mul ? op_a : mag_b;
                dividend <= op_a;
                div_zero <= (op_b == '0);
                neg_q    <= a_neg ^ b_neg;
                neg_r    <= a_neg;
                want_rem <= div_rem;
                if (!is_mul && !is_div) begin
                    alu_out <= result;
                    zero    <= (result == '0);
                end
            end else if (busy) begin
                acc   <= acc_step;
                shreg <= shreg_step;
                count <= count + 1'b1;
                if (state == MUL) opnd <= opnd << 1;
                if (finish) begin
                    alu_out <= mc_result;
                    zero    <= (mc_result == '0);
                end
            end

            if (flush)
                out_valid <= 1'b0;
            else if ((accept && !is_mul && !is_div) || finish)
                out_valid <= 1'b1;
            else if (out_ready)
                out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ex_alu_muldiv.sv
// Directed bench for ex_alu_muldiv: a reference model fills a scoreboard at
// issue time and each result is popped and compared when out_valid appears.
module tb_ex_alu_muldiv;
    localparam int XLEN = 32;

    localparam logic [3:0] ADD = 4'b0000, SUB = 4'b1000, SLT = 4'b0010, SLTU = 4'b0011;
    localparam logic [3:0] OR_ = 4'b0110, AND_ = 4'b0111, XOR_ = 4'b0100, PASS = 4'b1111;
    localparam logic [3:0] MUL = 4'b1001, DIV = 4'b1100, DIVU = 4'b1101;
    localparam logic [3:0] REM = 4'b1110, REMU = 4'b1011, BAD = 4'b0001;

    logic            clk = 1'b0;
    logic            rst_n, flush, in_valid, in_ready, a_src, out_valid, out_ready, zero, busy;
    logic [XLEN-1:0] pc, bus_a, bus_b, imm, alu_out, target;
    logic [3:0]      alu_ctr;
    logic [1:0]      b_src;

    typedef struct {
        logic [31:0] res;
        logic [31:0] tgt;
    } exp_t;

    exp_t scoreboard[$];
    int   vectors = 0;
    int   miscompares = 0;

    ex_alu_muldiv #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .pc(pc), .bus_a(bus_a), .bus_b(bus_b), .imm(imm),
        .alu_ctr(alu_ctr), .a_src(a_src), .b_src(b_src),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_out(alu_out), .target(target), .zero(zero), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input logic [3:0] ctr, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        logic ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (ctr)
            ADD:  return a + b;
            SUB:  return a - b;
            SLT:  return {31'd0, sa < sb};
            SLTU: return {31'd0, a < b};
            OR_:  return a | b;
            AND_: return a & b;
            XOR_: return a ^ b;
            PASS: return b;
            MUL:  return a * b;
            DIV:  return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
            DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            REM:  return (b == 0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
            REMU: return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Presents one request, waits (bounded) for acceptance, returns 1ns after the accepting edge.
    task automatic issue(input logic [3:0] ctr, input logic asrc, input logic [1:0] bsrc,
                         input logic [31:0] p, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im);
        logic [31:0] ea, eb;
        exp_t e;
        int waited;
        @(negedge clk);
        in_valid = 1'b1; alu_ctr = ctr; a_src = asrc; b_src = bsrc;
        pc = p; bus_a = a; bus_b = b; imm = im;
        waited = 0;
        while (in_ready !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("in_ready_timeout", 32'(in_ready), 32'd1);
        ea = asrc ? p : a;
        case (bsrc)
            2'b00:   eb = b;
            2'b01:   eb = 32'd4;
            2'b10:   eb = im;
            default: eb = 32'd0;
        endcase
        e.res = ref_alu(ctr, ea, eb);
        e.tgt = p + im;
        scoreboard.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Waits for out_valid, checking busy/in_ready while waiting, then compares against the scoreboard.
    task automatic expect_result(input string tag, input int lat_exp);
        exp_t e;
        int lat;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 100) begin
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
            @(posedge clk);
            #1 lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(lat_exp));
        vectors++;
        assert (scoreboard.size() != 0) else begin
            miscompares++;
            $error("FAIL %s_scoreboard: observed empty expected entry", tag);
        end
        if (scoreboard.size() != 0) begin
            e = scoreboard.pop_front();
            check({tag, "_alu_out"}, alu_out, e.res);
            check({tag, "_target"}, target, e.tgt);
            check({tag, "_zero"}, 32'(zero), 32'(e.res == 32'd0));
            check({tag, "_busy_done"}, 32'(busy), 32'd0);
        end
    endtask

    task automatic expect_silence(input string tag, input int cycles);
        int seen;
        seen = 0;
        repeat (cycles) begin
            @(posedge clk);
            #1 if (out_valid === 1'b1) seen++;
        end
        check(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        logic [31:0] hold_out, hold_tgt;
        logic        hold_zero;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a_src = 1'b0; b_src = 2'b00; alu_ctr = ADD;
        pc = '0; bus_a = '0; bus_b = '0; imm = '0;

        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_alu_out", alu_out, 32'd0);
        check("rst_target", target, 32'd0);
        check("rst_zero", 32'(zero), 32'd1);
        rst_n = 1'b1;

        issue(ADD, 1'b0, 2'b10, 32'h0000_1000, 32'd5, 32'd0, 32'hFFFF_FFFD);
        expect_result("add_imm", 1);
        issue(SLT, 1'b0, 2'b00, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'h10);
        expect_result("slt", 1);
        issue(SLTU, 1'b0, 2'b00, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'h10);
        expect_result("sltu", 1);
        issue(SUB, 1'b1, 2'b01, 32'h0000_2000, 32'd9, 32'd0, 32'h40);
        expect_result("sub_pc_4", 1);
        issue(OR_, 1'b0, 2'b00, 32'h4, 32'hF0F0_0000, 32'h0000_0F0F, 32'h8);
        expect_result("or", 1);
        issue(AND_, 1'b0, 2'b00, 32'h4, 32'hF0F0_FFFF, 32'h0F0F_00FF, 32'h8);
        expect_result("and", 1);
        issue(XOR_, 1'b0, 2'b00, 32'h8, 32'hAAAA_5555, 32'hAAAA_5555, 32'h4);
        expect_result("xor_zero", 1);
        issue(PASS, 1'b0, 2'b10, 32'h100, 32'd1, 32'd2, 32'h1234_5678);
        expect_result("pass_b", 1);
        issue(ADD, 1'b0, 2'b11, 32'h100, 32'h0BAD_F00D, 32'd7, 32'd3);
        expect_result("add_b_zero", 1);
        issue(BAD, 1'b0, 2'b00, 32'h100, 32'd3, 32'd4, 32'd0);
        expect_result("bad_code", 1);

        issue(MUL, 1'b0, 2'b00, 32'h200, 32'd7, 32'hFFFF_FFFD, 32'd8);
        expect_result("mul_neg", XLEN + 1);
        issue(MUL, 1'b0, 2'b00, 32'h200, 32'h1234_5678, 32'h9ABC_DEF1, 32'd8);
        expect_result("mul_big", XLEN + 1);
        issue(DIVU, 1'b0, 2'b00, 32'h300, 32'd10, 32'd0, 32'd4);
        expect_result("divu_by_zero", XLEN + 1);
        issue(REM, 1'b0, 2'b00, 32'h300, 32'd10, 32'd0, 32'd4);
        expect_result("rem_by_zero", XLEN + 1);
        issue(DIV, 1'b0, 2'b00, 32'h300, 32'h8000_0000, 32'hFFFF_FFFF, 32'd4);
        expect_result("div_overflow", XLEN + 1);
        issue(REM, 1'b0, 2'b00, 32'h300, 32'h8000_0000, 32'hFFFF_FFFF, 32'd4);
        expect_result("rem_overflow", XLEN + 1);
        issue(DIV, 1'b0, 2'b00, 32'h300, 32'hFFFF_FFF9, 32'd2, 32'd4);
        expect_result("div_neg", XLEN + 1);
        issue(REM, 1'b0, 2'b00, 32'h300, 32'hFFFF_FFF9, 32'd2, 32'd4);
        expect_result("rem_neg", XLEN + 1);
        issue(REMU, 1'b0, 2'b00, 32'h300, 32'd100, 32'd7, 32'd4);
        expect_result("remu", XLEN + 1);
        issue(DIVU, 1'b0, 2'b00, 32'h300, 32'hFFFF_FFFF, 32'd3, 32'd4);
        expect_result("divu_max", XLEN + 1);

        // Back-pressure: the result must stay frozen until it is taken.
        @(posedge clk);
        #1 out_ready = 1'b0;
        issue(ADD, 1'b0, 2'b00, 32'h400, 32'd20, 32'd22, 32'd12);
        expect_result("stall_add", 1);
        hold_out = alu_out; hold_tgt = target; hold_zero = zero;
        repeat (4) begin
            @(posedge clk);
            #1;
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_alu_out", alu_out, hold_out);
            check("stall_target", target, hold_tgt);
            check("stall_zero", 32'(zero), 32'(hold_zero));
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 check("stall_release", 32'(out_valid), 32'd0);

        // Flush at iteration 10 of a divide.
        issue(DIV, 1'b0, 2'b00, 32'h500, 32'd1000, 32'd7, 32'd4);
        void'(scoreboard.pop_back());
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        #1 check("flush_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        expect_silence("flush_no_result", 40);
        issue(ADD, 1'b0, 2'b00, 32'h600, 32'd1, 32'd2, 32'd3);
        expect_result("post_flush_add", 1);

        // Reset in the middle of a multiply.
        issue(MUL, 1'b0, 2'b00, 32'h700, 32'd11, 32'd13, 32'd4);
        void'(scoreboard.pop_back());
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_alu_out", alu_out, 32'd0);
        check("midrst_target", target, 32'd0);
        check("midrst_zero", 32'(zero), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        expect_silence("midrst_no_result", 40);
        issue(SUB, 1'b0, 2'b00, 32'h800, 32'd50, 32'd8, 32'd0);
        expect_result("post_reset_sub", 1);

        check("scoreboard_empty", 32'(scoreboard.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
